// File: rtl/fp2int_seq.sv
// Purpose: sequential IEEE-754 single to int32 converter with four rounding modes (bit-serial shifter).
// Latency: out_valid rises n+2 edges after accept, n = shift distance (0..26; 0 for special operands).
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE, one op in flight.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake; a (float bits) and rm (rounding mode) captured on accept
//   out_valid/out_ready result handshake; d (int32), invalid, inexact held stable while stalled
module fp2int_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [1:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] d,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state;
    logic [31:0] mag;        // magnitude being aligned; left shifts reach at most bit 30
    logic [4:0]  cnt;        // remaining shift steps
    logic        sign;
    logic [1:0]  rm_q;
    logic        dir_left;
    logic        guard;
    logic        sticky;
    logic        zero_exp;   // zero or denormal operand: always truncates to 0
    logic        special;    // result fixed at accept, ROUND only publishes it
    logic        spec_inv;
    logic [31:0] spec_val;

    // Operand decode, only consumed on the accepting edge.
    logic [7:0]  a_exp;
    logic [23:0] a_man;
    logic        a_nan;
    logic        a_big;
    logic        a_min;
    logic        a_left;
    logic [4:0]  a_cnt;

    always_comb begin
        a_exp  = a[30:23];
        a_man  = {|a_exp, a[22:0]};
        a_nan  = (a_exp == 8'hFF) && (a[22:0] != 23'd0);
        a_big  = (a_exp >= 8'd158);
        a_min  = (a == 32'hCF00_0000);
        a_left = (a_exp >= 8'd150);
        if (a_left)
            a_cnt = 5'(a_exp - 8'd150);
        else if (a_exp < 8'd124)
            a_cnt = 5'd26;            // everything already sits in guard/sticky after 26 steps
        else
            a_cnt = 5'(8'd150 - a_exp);
    end

    // Rounding increment; magnitude is at most 0x7FFFFF80 so +1 cannot overflow.
    logic        inc;
    logic [31:0] rnd_mag;

    always_comb begin
        case (rm_q)
            2'b00:   inc = guard & (sticky | mag[0]);
            2'b01:   inc = sign & (guard | sticky);
            2'b10:   inc = ~sign & (guard | sticky);
            default: inc = 1'b0;
        endcase
        if (zero_exp)
            inc = 1'b0;
        rnd_mag = mag + {31'd0, inc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= 32'd0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
            mag       <= 32'd0;
            cnt       <= 5'd0;
            sign      <= 1'b0;
            rm_q      <= 2'b00;
            dir_left  <= 1'b0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
            zero_exp  <= 1'b0;
            special   <= 1'b0;
            spec_inv  <= 1'b0;
            spec_val  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign     <= a[31];
                        rm_q     <= rm;
                        mag      <= {8'd0, a_man};
                        guard    <= 1'b0;
                        sticky   <= 1'b0;
                        zero_exp <= (a_exp == 8'd0);
                        dir_left <= a_left;
                        if (a_nan || (a_big && !a_min)) begin
                            special  <= 1'b1;
                            spec_inv <= 1'b1;
                            spec_val <= (a_nan || !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
                            cnt      <= 5'd0;
                            state    <= ROUND;
                        end else if (a_min) begin
                            // -2^31 is exactly representable
                            special  <= 1'b1;
                            spec_inv <= 1'b0;
                            spec_val <= 32'h8000_0000;
                            cnt      <= 5'd0;
                            state    <= ROUND;
                        end else begin
                            special  <= 1'b0;
                            spec_inv <= 1'b0;
                            spec_val <= 32'd0;
                            cnt      <= a_cnt;
                            state    <= (a_cnt == 5'd0) ? ROUND : SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (dir_left) begin
                        mag <= {mag[30:0], 1'b0};
                    end else begin
                        mag    <= {1'b0, mag[31:1]};
                        guard  <= mag[0];
                        sticky <= sticky | guard;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= ROUND;
                end
                ROUND: begin
                    if (special) begin
                        d       <= spec_val;
                        invalid <= spec_inv;
                        inexact <= 1'b0;
                    end else begin
                        d       <= sign ? -rnd_mag : rnd_mag;
                        invalid <= 1'b0;
                        inexact <= guard | sticky;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle lets the result settle; out_valid follows a cycle later.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp2int_seq.sv
module tb_fp2int_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [1:0]  rm = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] d;
    logic        invalid;
    logic        inexact;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        inv;
        logic        inx;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    logic        pov = 1'b0;
    logic        prdy = 1'b0;
    logic [31:0] pd = 32'd0;
    logic        pinv = 1'b0;
    logic        pinx = 1'b0;

    logic [31:0] dir_a [18] = '{32'h3FC00000, 32'h40200000, 32'h40200000, 32'h40200000,
                                32'hBFC00000, 32'hBFC00000, 32'hBFC00000, 32'h4EFFFFFF,
                                32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'h80000000,
                                32'h00000001, 32'h80000001, 32'h7F800000, 32'hFF800000,
                                32'hCF000001, 32'h4B000001};
    logic [1:0]  dir_rm [18] = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0,
                                 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd3,
                                 2'd0, 2'd0};

    fp2int_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Exact value is m * 2^(e-150); rounding decided from integer quotient and remainder.
    function automatic exp_t ref_model(input logic [31:0] x, input logic [1:0] r, output int n);
        exp_t   e;
        int     ex;
        int     sh;
        longint m, q, rem, unit, mag;
        bit     s, any, above, tie, up;
        ex    = int'(x[30:23]);
        m     = {40'd0, (ex != 0), x[22:0]};
        s     = x[31];
        e.a   = x;
        e.inv = 1'b0;
        e.inx = 1'b0;
        e.cyc = 0;
        n     = 0;
        q = 0; any = 0; above = 0; tie = 0; up = 0;
        if (x == 32'hCF000000) begin
            e.d = 32'h80000000;
        end else if (ex == 255 && x[22:0] != 23'd0) begin
            e.d = 32'h7FFFFFFF;
            e.inv = 1'b1;
        end else if (ex >= 158) begin
            e.d = s ? 32'h80000000 : 32'h7FFFFFFF;
            e.inv = 1'b1;
        end else begin
            if (ex >= 150) begin
                q = m * (longint'(1) << (ex - 150));
                n = ex - 150;
            end else begin
                sh = 150 - ex;
                n  = (sh > 26) ? 26 : sh;
                if (sh >= 40) begin
                    any = (m != 0);           // value far below one half
                end else begin
                    unit  = longint'(1) << sh;
                    q     = m / unit;
                    rem   = m % unit;
                    any   = (rem != 0);
                    above = (rem * 2 > unit);
                    tie   = (rem * 2 == unit);
                end
            end
            case (r)
                2'd0:    up = above || (tie && (q % 2 == 1));
                2'd1:    up = s && any;
                2'd2:    up = !s && any;
                default: up = 1'b0;
            endcase
            if (ex == 0)
                up = 1'b0;
            mag   = q + longint'(up);
            e.d   = s ? 32'(-mag) : 32'(mag);
            e.inx = any;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [31:0] x, input logic [1:0] r);
        int   waited = 0;
        int   n;
        exp_t e;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL issue_wait: in_ready=0 after %0d cycles, expected 1", waited);
            return;
        end
        in_valid = 1'b1;
        a  = x;
        rm = r;
        e  = ref_model(x, r, n);
        e.cyc = cyc + 1 + n + 2;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a  = $urandom;                 // must be ignored after accept
        rm = 2'($urandom_range(0, 3));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      ex = 8'($urandom_range(0, 255));
        else if (sel == 1) ex = 8'd0;
        else if (sel == 2) ex = 8'($urandom_range(150, 160));
        else               ex = 8'($urandom_range(120, 157));
        fr = 23'($urandom);
        if ($urandom_range(0, 3) == 0)
            fr = fr & ~((23'd1 << $urandom_range(0, 22)) - 23'd1);
        return {1'($urandom_range(0, 1)), ex, fr};
    endfunction

    // Monitor: decides out_ready at each negedge, pops on handshake, checks latency and hold stability.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                check("in_ready_in_done", in_ready, 1'b0);
                if (!pov) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: d=%h with nothing pending", d);
                    end else begin
                        check("latency", cyc, sb[0].cyc);
                    end
                end else if (!prdy) begin
                    check("hold_stable", {d, invalid, inexact}, {pd, pinv, pinx});
                end
                if (stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    total++;
                    if (d !== e.d || invalid !== e.inv || inexact !== e.inx) begin
                        bad++;
                        $display("FAIL result a=%h: got d=%h inv=%b inx=%b, expected d=%h inv=%b inx=%b",
                                 e.a, d, invalid, inexact, e.d, e.inv, e.inx);
                    end
                end
            end else begin
                out_ready = ($urandom_range(0, 1) == 1);
            end
            pov  = out_valid;
            prdy = out_ready;
            pd   = d;
            pinv = invalid;
            pinx = inexact;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit reached");
    end

    initial begin
        int w;
        // Reset with an operand offered throughout: it must not be taken.
        rst = 1'b1;
        in_valid = 1'b1;
        a = 32'h3FC00000;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_d", d, 32'd0);
        check("rst_invalid", invalid, 1'b0);
        check("rst_inexact", inexact, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("no_accept_in_reset", in_ready, 1'b1);

        foreach (dir_a[i]) begin
            issue(dir_a[i], dir_rm[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Consumer stalls five cycles: monitor checks hold stability and in_ready.
        @(posedge clk); #1 stall = 5;
        @(negedge clk);
        issue(32'h40200000, 2'd2);

        // Reset during the 10th SHIFT cycle of 1.0.
        issue(32'h3F800000, 2'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("mid_shift_rst_out_valid", out_valid, 1'b0);
        check("mid_shift_rst_in_ready", in_ready, 1'b1);
        check("mid_shift_rst_d", d, 32'd0);
        repeat (40) @(negedge clk);
        check("no_stale_result", out_valid, 1'b0);

        // Reset while a result is held in DONE.
        @(posedge clk); #1 stall = 50;
        @(negedge clk);
        issue(32'hC12B3333, 2'd1);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("held_done_reached", out_valid, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 begin sb.delete(); stall = 0; end
        @(negedge clk);
        rst = 1'b0;
        check("done_rst_out_valid", out_valid, 1'b0);
        check("done_rst_in_ready", in_ready, 1'b1);
        check("done_rst_d", d, 32'd0);
        check("done_rst_flags", {invalid, inexact}, 2'b00);
        repeat (40) @(negedge clk);
        check("no_stale_after_done_rst", out_valid, 1'b0);

        for (int k = 0; k < 150; k++) begin
            issue(rand_operand(), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        w = 0;
        while (sb.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
